cordic_vectoring_iter: RTL and testbench

//  Iterative vectoring-mode CORDIC, the inverse of the cosine rotation pipeline: takes a fixed-point

---
 rtl/cordic_vectoring_iter.sv | 196 +++++++++++++++++++
 tb/tb_cordic_vectoring_iter.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_vectoring_iter.sv
// cordic_vectoring_iter
//   Iterative vectoring-mode CORDIC. One shared micro-rotation stage drives (x,y) onto the
//   +x axis. The rotation angle builds up in z (atan2(y,x)), and the scaled vector length is
//   left in x. Inputs are Q1.20 (21 b). The datapath and the outputs are Q3.20 (23 b).
//   Build macro CORDIC_VEC_GAIN_COMP_EN adds a one-cycle COMP state. That state multiplies the
//   raw magnitude by K = 0.607253 to remove the CORDIC gain. Without the macro, magnitude
//   carries the gain of 1.646760.
//
//   state | meaning
//   IDLE  | waiting for start
//   ITER  | one micro-rotation per enabled cycle; the final cycle (cnt == ITERS) only hands off
//   COMP  | gain-compensation multiply (macro builds only)
//   DONE  | results registered, one-cycle done pulse
module cordic_vectoring_iter #(
  parameter int ITERS = 16,
  parameter int IN_W  = 21,
  parameter int OUT_W = 23
) (
  input  logic             clock,
  input  logic             aclr,
  input  logic             clk_en,
  input  logic             start,
  input  logic [IN_W-1:0]  x_in,
  input  logic [IN_W-1:0]  y_in,
  output logic             busy,
  output logic             done,
  output logic [OUT_W-1:0] angle,
  output logic [OUT_W-1:0] magnitude
);

  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic signed [OUT_W-1:0] HALF_PI = 23'sh1921FB;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_COMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]        cnt;
  logic [3:0]              idx;
  logic                    last;
  logic                    accept;
  logic                    finish;
  logic                    zero_r;
  logic signed [OUT_W-1:0] x_r, y_r, z_r;
  logic signed [OUT_W-1:0] x_ext, y_ext;
  logic signed [OUT_W-1:0] x_load, y_load, z_load;
  logic signed [OUT_W-1:0] x_sh, y_sh, atan_i;
  logic signed [OUT_W-1:0] x_step, y_step, z_step;
  logic signed [OUT_W-1:0] mag_next;

  // atan(2^-i) in Q.20
  function automatic logic signed [OUT_W-1:0] atan_lut(input logic [3:0] i);
    case (i)
      4'd0:    atan_lut = 23'sh0C90FE;
      4'd1:    atan_lut = 23'sh076B1A;
      4'd2:    atan_lut = 23'sh03EB6F;
      4'd3:    atan_lut = 23'sh01FD5C;
      4'd4:    atan_lut = 23'sh00FFAB;
      4'd5:    atan_lut = 23'sh007FF5;
      4'd6:    atan_lut = 23'sh003FFF;
      4'd7:    atan_lut = 23'sh002000;
      4'd8:    atan_lut = 23'sh001000;
      4'd9:    atan_lut = 23'sh000800;
      4'd10:   atan_lut = 23'sh000400;
      4'd11:   atan_lut = 23'sh000200;
      4'd12:   atan_lut = 23'sh000100;
      4'd13:   atan_lut = 23'sh000080;
      4'd14:   atan_lut = 23'sh000040;
      default: atan_lut = 23'sh000020;
    endcase
  endfunction

  assign x_ext  = {{(OUT_W-IN_W){x_in[IN_W-1]}}, x_in};
  assign y_ext  = {{(OUT_W-IN_W){y_in[IN_W-1]}}, y_in};
  assign idx    = 4'(cnt);
  assign last   = (cnt == CNT_W'(ITERS));
  assign accept = (state == S_IDLE) && start;
  assign atan_i = atan_lut(idx);

`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam logic signed [21:0] K_GAIN = 22'sh09B74F;
  logic signed [OUT_W+21:0] prod;
  assign prod     = x_r * K_GAIN;
  assign mag_next = OUT_W'(prod >>> 20);
  assign finish   = (state == S_COMP);
`else
  assign mag_next = x_r;
  assign finish   = (state == S_ITER) && last;
`endif

  // Pre-rotate left-half-plane vectors by +/-pi/2 so the iterations only have to cover +/-pi/2
  always_comb begin
    x_load = x_ext;
    y_load = y_ext;
    z_load = '0;
    if (x_ext[OUT_W-1]) begin
      if (!y_ext[OUT_W-1]) begin
        x_load = y_ext;
        y_load = -x_ext;
        z_load = HALF_PI;
      end else begin
        x_load = -y_ext;
        y_load = x_ext;
        z_load = -HALF_PI;
      end
    end
  end

  // One micro-rotation toward y = 0, using the pre-step x and y
  always_comb begin
    x_sh = x_r >>> idx;
    y_sh = y_r >>> idx;
    if (!y_r[OUT_W-1]) begin
      x_step = x_r + y_sh;
      y_step = y_r - x_sh;
      z_step = z_r + atan_i;
    end else begin
      x_step = x_r - y_sh;
      y_step = y_r + x_sh;
      z_step = z_r - atan_i;
    end
  end

  // State register; clk_en low freezes the sequence
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr)        state <= S_IDLE;
    else if (clk_en) state <= state_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_ITER;
      end
      S_ITER: begin
        busy = 1'b1;
`ifdef CORDIC_VEC_GAIN_COMP_EN
        if (last) state_next = S_COMP;
`else
        if (last) state_next = S_DONE;
`endif
      end
`ifdef CORDIC_VEC_GAIN_COMP_EN
      S_COMP: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
`endif
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Operand load, iteration datapath and result capture on entry to DONE
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      x_r       <= '0;
      y_r       <= '0;
      z_r       <= '0;
      cnt       <= '0;
      zero_r    <= 1'b0;
      angle     <= '0;
      magnitude <= '0;
    end else if (clk_en) begin
      if (accept) begin
        x_r    <= x_load;
        y_r    <= y_load;
        z_r    <= z_load;
        cnt    <= '0;
        zero_r <= (x_in == '0) && (y_in == '0);
      end else if ((state == S_ITER) && !last) begin
        x_r <= x_step;
        y_r <= y_step;
        z_r <= z_step;
        cnt <= cnt + CNT_W'(1);
      end
      if (finish) begin
        angle     <= zero_r ? '0 : z_r;
        magnitude <= zero_r ? '0 : mag_next;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vectoring_iter.sv
// tb_cordic_vectoring_iter
//   Directed and random vectors for cordic_vectoring_iter. Expected results come from
//   real-valued atan2 / sqrt; latency, stall, abort and retrigger behaviour are checked too.
//   Honours CORDIC_VEC_GAIN_COMP_EN in the same way as the design.
module tb_cordic_vectoring_iter;

  localparam int  ITERS   = 16;
  localparam real SCALE   = 1048576.0;
  localparam real ANG_TOL = 32.0;
  // The last micro-rotation can leave up to atan(2^-15) ~ 32 LSB of residual angle, and floor
  // truncation in the shifts tilts the vector a few LSB more, so arbitrary vectors get headroom.
  localparam real ANG_TOL_RAND = 48.0;
  localparam real MAG_TOL = 64.0;
  localparam int  LIM     = 996147;                 // 0.95 in Q.20
  localparam longint MIN2 = 64'd274877906944;       // (0.5 in Q.20)^2
`ifdef CORDIC_VEC_GAIN_COMP_EN
  localparam int  LAT  = ITERS + 2;
  localparam real GAIN = 1.0;
`else
  localparam int  LAT  = ITERS + 1;
  localparam real GAIN = 1.646760258;
`endif

  logic        clock = 1'b0;
  logic        aclr;
  logic        clk_en;
  logic        start;
  logic [20:0] x_in;
  logic [20:0] y_in;
  logic        busy;
  logic        done;
  logic [22:0] angle;
  logic [22:0] magnitude;

  int n_vec  = 0;
  int n_miss = 0;

  cordic_vectoring_iter #(.ITERS(ITERS), .IN_W(21), .OUT_W(23)) dut (
    .clock     (clock),
    .aclr      (aclr),
    .clk_en    (clk_en),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .busy      (busy),
    .done      (done),
    .angle     (angle),
    .magnitude (magnitude)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input real obs, input real exp, input real tol);
    real d;
    d = obs - exp;
    if (d < 0.0) d = -d;
    n_vec++;
    assert ((d <= tol) === 1'b1)
    else begin
      n_miss++;
      $error("FAIL %s: observed %0.1f, expected %0.1f (+/-%0.0f)", tag, obs, exp, tol);
    end
  endtask

  // Reference: ideal atan2 and (gain-scaled) Euclidean length of the input vector
  task automatic chk_model(input string tag, input logic [20:0] xv, input logic [20:0] yv,
                           input real atol);
    real xr, yr, ea, em;
    int  ai, mi;
    xr = real'(int'($signed(xv))) / SCALE;
    yr = real'(int'($signed(yv))) / SCALE;
    ai = int'($signed(angle));
    mi = int'(magnitude);
    if (xv == 21'd0 && yv == 21'd0) begin
      chk({tag, "_ang"}, angle, 64'd0);
      chk({tag, "_mag"}, magnitude, 64'd0);
    end else begin
      ea = $atan2(yr, xr) * SCALE;
      em = $sqrt(xr * xr + yr * yr) * GAIN * SCALE;
      chk_tol({tag, "_ang"}, real'(ai), ea, atol);
      chk_tol({tag, "_mag"}, real'(mi), em, MAG_TOL);
    end
  endtask

  task automatic pick_vec(output logic [20:0] xv, output logic [20:0] yv);
    int a, b;
    a = LIM;
    b = 0;
    for (int t = 0; t < 100; t++) begin
      a = int'($urandom_range(2 * LIM, 0)) - LIM;
      b = int'($urandom_range(2 * LIM, 0)) - LIM;
      if (longint'(a) * a + longint'(b) * b >= MIN2) break;
    end
    xv = 21'(a);
    yv = 21'(b);
  endtask

  // One job: lat = enabled+stalled cycles from the accept edge to the first done (-1 on timeout)
  task automatic run_vec(input logic [20:0] xv, input logic [20:0] yv, input int stall_at,
                         input int stall_len, input bit poke, output int lat);
    tick();
    x_in  = xv;
    y_in  = yv;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on_accept", busy, 64'd1);
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      clk_en = !((c >= stall_at) && (c < stall_at + stall_len));
      start  = poke && (c == 4);
      tick();
      if (done) begin
        lat = c + 1;
        break;
      end
    end
    clk_en = 1'b1;
    start  = 1'b0;
    chk("busy_at_done", busy, 64'd0);
  endtask

  initial begin
    logic [20:0] rx, ry;
    int lat, nd;

    aclr   = 1'b1;
    clk_en = 1'b1;
    start  = 1'b0;
    x_in   = '0;
    y_in   = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", busy, 64'd0);
    chk("rst_done", done, 64'd0);
    chk("rst_angle", angle, 64'd0);
    chk("rst_mag", magnitude, 64'd0);
    aclr = 1'b0;
    tick();

    run_vec(21'h080000, 21'h000000, -1, 0, 1'b0, lat);
    chk("lat_plus_x", lat, 64'(LAT));
    chk_model("plus_x", 21'h080000, 21'h000000, ANG_TOL);

    run_vec(21'h000000, 21'h080000, -1, 0, 1'b0, lat);
    chk_model("plus_y", 21'h000000, 21'h080000, ANG_TOL);

    run_vec(21'h000000, 21'h180000, -1, 0, 1'b0, lat);
    chk_model("minus_y", 21'h000000, 21'h180000, ANG_TOL);

    run_vec(21'h180000, 21'h000000, -1, 0, 1'b0, lat);
    chk_model("minus_x", 21'h180000, 21'h000000, ANG_TOL);

    run_vec(21'h180000, 21'h1FFFFF, -1, 0, 1'b0, lat);
    chk_model("minus_x_neg_tiny", 21'h180000, 21'h1FFFFF, ANG_TOL);

    run_vec(21'h05A827, 21'h05A827, -1, 0, 1'b0, lat);
    chk_model("diag", 21'h05A827, 21'h05A827, ANG_TOL);

    for (int k = 0; k < 12; k++) begin
      pick_vec(rx, ry);
      run_vec(rx, ry, -1, 0, 1'b0, lat);
      chk("lat_rand", lat, 64'(LAT));
      chk_model("rand", rx, ry, ANG_TOL_RAND);
    end

    // clk_en low for 5 cycles mid-ITER, plus a start pulse while busy
    pick_vec(rx, ry);
    run_vec(rx, ry, 6, 5, 1'b1, lat);
    chk("lat_stall", lat, 64'(LAT + 5));
    chk_model("stall", rx, ry, ANG_TOL_RAND);
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done || busy) nd++;
    end
    chk("no_second_job", nd, 64'd0);

    // abort at iteration step 8
    x_in  = 21'h0C0000;
    y_in  = 21'h040000;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("busy_before_abort", busy, 64'd1);
    aclr = 1'b1;
    #1;
    chk("abort_busy", busy, 64'd0);
    chk("abort_done", done, 64'd0);
    chk("abort_angle", angle, 64'd0);
    chk("abort_mag", magnitude, 64'd0);
    @(negedge clock);
    aclr = 1'b0;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done) nd++;
    end
    chk("no_done_after_abort", nd, 64'd0);

    run_vec(21'h000000, 21'h000000, -1, 0, 1'b0, lat);
    chk("lat_zero", lat, 64'(LAT));
    chk_model("zero", 21'h000000, 21'h000000, ANG_TOL);

    // start held high: one idle cycle after DONE, then a new job
    tick();
    x_in  = 21'h080000;
    y_in  = 21'h080000;
    start = 1'b1;
    tick();
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done) begin
        lat = c + 1;
        break;
      end
    end
    chk("lat_held_start", lat, 64'(LAT));
    chk_model("held", 21'h080000, 21'h080000, ANG_TOL);
    tick();
    chk("idle_after_done", busy, 64'd0);
    tick();
    chk("retrigger_busy", busy, 64'd1);
    start = 1'b0;
    lat = -1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (done) begin
        lat = c + 1;
        break;
      end
    end
    chk("lat_retrigger", lat, 64'(LAT));
    chk_model("retrigger", 21'h080000, 21'h080000, ANG_TOL);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
